// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the L1 cache side and the 64-bit physical-memory burst side.
// The slave modport is the adaptor's view; the master modport is the cache/memory view.
interface cacheline_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into a 4-beat 64-bit memory burst, one transaction at a time.
// Optional macro CACHELINE_ADAPTOR_PERF_EN adds saturating read/write/wait-cycle counters.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.slave bus
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0] perf_reads_o,
  output logic [31:0] perf_writes_o,
  output logic [31:0] perf_wait_o
`endif
);
  localparam int BEATS = s_line / s_burst;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_t;

  state_t                         r_state;
  logic [BW-1:0]                  r_beat;
  logic [31:0]                    r_addr;
  logic [BEATS-1:0][s_burst-1:0]  r_buf;
  logic                           r_read;
  logic                           r_write;
  logic                           r_resp;
  logic                           w_last;

  assign w_last = (r_beat == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          // Read has priority; a concurrent write is picked up on a later IDLE cycle.
          if (bus.read_i) begin
            r_addr  <= {bus.address_i[31:s_offset], {s_offset{1'b0}}};
            r_beat  <= '0;
            r_read  <= 1'b1;
            r_state <= RD;
          end else if (bus.write_i) begin
            r_addr  <= {bus.address_i[31:s_offset], {s_offset{1'b0}}};
            r_buf   <= bus.line_i;
            r_beat  <= '0;
            r_write <= 1'b1;
            r_state <= WR;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            r_buf[r_beat] <= bus.burst_i;
            r_beat        <= r_beat + 1'b1;
            if (w_last) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= RD_DONE;
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            r_beat <= r_beat + 1'b1;
            if (w_last) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= WR_DONE;
            end
          end
        end
        RD_DONE, WR_DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_buf;
  // Beat mux is a decode of registered state only; quiet outside a write burst.
  assign bus.burst_o   = r_write ? r_buf[r_beat] : '0;

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] r_perf_reads;
  logic [31:0] r_perf_writes;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_reads  <= '0;
      r_perf_writes <= '0;
      r_perf_wait   <= '0;
    end else begin
      if (r_state == RD_DONE && r_perf_reads != '1)
        r_perf_reads <= r_perf_reads + 32'd1;
      if (r_state == WR_DONE && r_perf_writes != '1)
        r_perf_writes <= r_perf_writes + 32'd1;
      if ((r_state == RD || r_state == WR) && !bus.resp_i && r_perf_wait != '1)
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_reads_o  = r_perf_reads;
  assign perf_writes_o = r_perf_writes;
  assign perf_wait_o   = r_perf_wait;
`endif
endmodule
